// File: rtl/mips_regfile_mp_if.sv
// Register-file bus: two write ports, load-issue marking, and two read ports with busy flags.
interface mips_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              WriteEnable0;
    logic [ADDR_W-1:0] WriteAddress0;
    logic [DATA_W-1:0] WriteData0;
    logic              WriteEnable1;
    logic [ADDR_W-1:0] WriteAddress1;
    logic [DATA_W-1:0] WriteData1;
    logic [ADDR_W-1:0] ReadAddress1;
    logic [ADDR_W-1:0] ReadAddress2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              IssueValid;
    logic [ADDR_W-1:0] IssueAddress;
    logic              Busy1;
    logic              Busy2;

    modport master (
        output WriteEnable0, WriteAddress0, WriteData0,
        output WriteEnable1, WriteAddress1, WriteData1,
        output ReadAddress1, ReadAddress2, IssueValid, IssueAddress,
        input  ReadData1, ReadData2, Busy1, Busy2
    );

    modport slave (
        input  WriteEnable0, WriteAddress0, WriteData0,
        input  WriteEnable1, WriteAddress1, WriteData1,
        input  ReadAddress1, ReadAddress2, IssueValid, IssueAddress,
        output ReadData1, ReadData2, Busy1, Busy2
    );
endinterface

// File: rtl/mips_regfile_mp.sv
// Two-write/two-read MIPS register file with a per-register load-pending busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and busy clears) to the read ports.
module mips_regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic              clk,
    input logic              rst_n,
    mips_regfile_mp_if.slave rf
);
    localparam int REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [REGS];
    logic [REGS-1:0]   busy;
    logic [REGS-1:0]   busyNext;
    logic              wr0Act;
    logic              wr1Act;
    logic              issAct;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    assign wr0Act = rf.WriteEnable0 && (rf.WriteAddress0 != '0);
    assign wr1Act = rf.WriteEnable1 && (rf.WriteAddress1 != '0);
    assign issAct = rf.IssueValid && (rf.IssueAddress != '0);

    // Clear before set so a same-cycle issue and load writeback leave the register busy.
    always_comb begin
        busyNext = busy;
        if (wr1Act) busyNext[rf.WriteAddress1] = 1'b0;
        if (issAct) busyNext[rf.IssueAddress] = 1'b1;
        busyNext[0] = 1'b0;
    end

    // Port 1 is written last so the load result wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr0Act) regs[rf.WriteAddress0] <= rf.WriteData0;
            if (wr1Act) regs[rf.WriteAddress1] <= rf.WriteData1;
            busy <= busyNext;
        end
    end

    assign stored1 = (rf.ReadAddress1 == '0) ? '0 : regs[rf.ReadAddress1];
    assign stored2 = (rf.ReadAddress2 == '0) ? '0 : regs[rf.ReadAddress2];

`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by rst_n so nothing leaks out while the array is held cleared.
    always_comb begin
        rf.ReadData1 = stored1;
        if (rst_n && wr1Act && rf.WriteAddress1 == rf.ReadAddress1)
            rf.ReadData1 = rf.WriteData1;
        else if (rst_n && wr0Act && rf.WriteAddress0 == rf.ReadAddress1)
            rf.ReadData1 = rf.WriteData0;

        rf.ReadData2 = stored2;
        if (rst_n && wr1Act && rf.WriteAddress1 == rf.ReadAddress2)
            rf.ReadData2 = rf.WriteData1;
        else if (rst_n && wr0Act && rf.WriteAddress0 == rf.ReadAddress2)
            rf.ReadData2 = rf.WriteData0;

        rf.Busy1 = busy[rf.ReadAddress1];
        if (rst_n && wr1Act && rf.WriteAddress1 == rf.ReadAddress1
            && !(issAct && rf.IssueAddress == rf.ReadAddress1))
            rf.Busy1 = 1'b0;

        rf.Busy2 = busy[rf.ReadAddress2];
        if (rst_n && wr1Act && rf.WriteAddress1 == rf.ReadAddress2
            && !(issAct && rf.IssueAddress == rf.ReadAddress2))
            rf.Busy2 = 1'b0;
    end
`else
    always_comb begin
        rf.ReadData1 = stored1;
        rf.ReadData2 = stored2;
        rf.Busy1     = busy[rf.ReadAddress1];
        rf.Busy2     = busy[rf.ReadAddress2];
    end
`endif
endmodule

// File: tb/tb_mips_regfile_mp.sv
// Scoreboard bench for mips_regfile_mp: stimulus queues expected read-port values, a negedge monitor checks them.
module tb_mips_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string             name;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic              b1;
        logic              b2;
    } expT;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    expT  expQ[$];

    mips_regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rfIf ();

    mips_regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rfIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; the expectation applies at the following falling edge.
    task automatic applyStimulus(
        input logic we0, input logic [ADDR_W-1:0] wa0, input logic [DATA_W-1:0] wd0,
        input logic we1, input logic [ADDR_W-1:0] wa1, input logic [DATA_W-1:0] wd1,
        input logic iv,  input logic [ADDR_W-1:0] ia,
        input logic [ADDR_W-1:0] ra1, input logic [ADDR_W-1:0] ra2
    );
        @(posedge clk);
        #1;
        rfIf.WriteEnable0  = we0;
        rfIf.WriteAddress0 = wa0;
        rfIf.WriteData0    = wd0;
        rfIf.WriteEnable1  = we1;
        rfIf.WriteAddress1 = wa1;
        rfIf.WriteData1    = wd1;
        rfIf.IssueValid    = iv;
        rfIf.IssueAddress  = ia;
        rfIf.ReadAddress1  = ra1;
        rfIf.ReadAddress2  = ra2;
    endtask

    task automatic idle(input logic [ADDR_W-1:0] ra1, input logic [ADDR_W-1:0] ra2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, ra1, ra2);
    endtask

    task automatic checkOutput(
        input string name, input logic [DATA_W-1:0] rd1, input logic [DATA_W-1:0] rd2,
        input logic b1, input logic b2
    );
        expT e;
        e.name = name;
        e.rd1  = rd1;
        e.rd2  = rd2;
        e.b1   = b1;
        e.b2   = b2;
        expQ.push_back(e);
    endtask

    task automatic compareField(input string name, input string field,
                                input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
        end
    endtask

    // Monitor: the read ports are always presenting, so every queued expectation is consumed at the next falling edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            compareField(e.name, "ReadData1", rfIf.ReadData1, e.rd1);
            compareField(e.name, "ReadData2", rfIf.ReadData2, e.rd2);
            compareField(e.name, "Busy1", {{(DATA_W-1){1'b0}}, rfIf.Busy1}, {{(DATA_W-1){1'b0}}, e.b1});
            compareField(e.name, "Busy2", {{(DATA_W-1){1'b0}}, rfIf.Busy2}, {{(DATA_W-1){1'b0}}, e.b2});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        rfIf.WriteEnable0 = 0; rfIf.WriteAddress0 = 0; rfIf.WriteData0 = 0;
        rfIf.WriteEnable1 = 0; rfIf.WriteAddress1 = 0; rfIf.WriteData1 = 0;
        rfIf.IssueValid = 0; rfIf.IssueAddress = 0;
        rfIf.ReadAddress1 = 0; rfIf.ReadAddress2 = 0;

        idle(5, 0);
        checkOutput("resetInit", 0, 0, 0, 0);

        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5);
        rst_n = 1'b1;
        checkOutput("writeR5", BYP ? 32'hDEADBEEF : 0, BYP ? 32'hDEADBEEF : 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 6, 5, 6);
        checkOutput("readR5", 32'hDEADBEEF, 0, 0, 0);

        // Asynchronous reset mid-cycle while a write and an issue are pending.
        applyStimulus(1, 5, 32'h55555555, 1, 6, 32'h66666666, 1, 7, 5, 6);
        rst_n = 1'b0;
        checkOutput("resetMid", 0, 0, 0, 0);
        idle(5, 6);
        rst_n = 1'b1;
        checkOutput("afterReset", 0, 0, 0, 0);

        applyStimulus(1, 0, 32'h12345678, 1, 0, 32'h12345678, 1, 0, 0, 0);
        checkOutput("r0WriteCycle", 0, 0, 0, 0);
        idle(0, 0);
        checkOutput("r0After", 0, 0, 0, 0);

        applyStimulus(1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0, 7, 7);
        checkOutput("collideCycle", BYP ? 32'h22222222 : 0, BYP ? 32'h22222222 : 0, 0, 0);
        idle(0, 7);
        checkOutput("collideAfter", 0, 32'h22222222, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
        checkOutput("issueR9Cycle", 0, 0, 0, 0);
        idle(9, 9);
        checkOutput("r9Busy", 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 9, 32'hA5A5A5A5, 0, 0, 9, 0);
        checkOutput("loadR9Cycle", BYP ? 32'hA5A5A5A5 : 0, 0, BYP ? 1'b0 : 1'b1, 0);
        idle(9, 7);
        checkOutput("loadR9After", 32'hA5A5A5A5, 32'h22222222, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        checkOutput("reissueR9", 32'hA5A5A5A5, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 9, 32'h5A5A5A5A, 1, 9, 9, 9);
        checkOutput("raceCycle", BYP ? 32'h5A5A5A5A : 32'hA5A5A5A5, BYP ? 32'h5A5A5A5A : 32'hA5A5A5A5, 1, 1);
        idle(9, 0);
        checkOutput("raceAfter", 32'h5A5A5A5A, 0, 1, 0);

        // Port 0 must not clear busy; a repeated issue keeps it set.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 10, 10);
        checkOutput("issueR10", 0, 0, 0, 0);
        applyStimulus(1, 10, 32'h0F0F0F0F, 0, 0, 0, 1, 10, 10, 9);
        checkOutput("port0R10Cycle", BYP ? 32'h0F0F0F0F : 0, 32'h5A5A5A5A, 1, 1);
        idle(10, 10);
        checkOutput("port0R10After", 32'h0F0F0F0F, 32'h0F0F0F0F, 1, 1);

        // Clearing an idle bit leaves it clear.
        applyStimulus(0, 0, 0, 1, 11, 32'h0000ABCD, 0, 0, 0, 11);
        checkOutput("clearIdleCycle", 0, BYP ? 32'h0000ABCD : 0, 0, 0);
        idle(11, 10);
        checkOutput("clearIdleAfter", 32'h0000ABCD, 32'h0F0F0F0F, 0, 1);

        applyStimulus(1, 3, 32'hCAFEF00D, 0, 0, 0, 0, 0, 3, 3);
        checkOutput("bypassR3Cycle", BYP ? 32'hCAFEF00D : 0, BYP ? 32'hCAFEF00D : 0, 0, 0);
        idle(3, 0);
        checkOutput("bypassR3After", 32'hCAFEF00D, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d required=0 pending", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
